div_unit: RTL and testbench

Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the EX stage. It is the requester side of the pipeline stall handshake: while a division is in flight it drives `stallreq_o` into the stall controller, which freezes the front of the pipeline. On completion it presents a one-cycle `ready_o` with the result, then releases the stall.

---
 rtl/div_unit.sv | 106 ++++++++++
 tb/tb_div_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU; one quotient bit per cycle.
// Holds stallreq_o while a division is in flight and strobes ready_o for one cycle with the result.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            annul_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            stallreq_o,
  output logic [1:0]      state_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  // Handshake: start_i is held high with stable operands until ready_o; ready_o is a
  // single-cycle strobe; stallreq_o is high from the accepting IDLE cycle through the last BUSY cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
  logic            is_rem_q, neg_quo_q, neg_rem_q;

  logic            signed_op, dvd_neg, dvs_neg, div_zero, ovf, accept;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] quo_step, rem_step, quo_fix, rem_fix, final_res;

  assign signed_op = ~op_i[0];
  assign dvd_neg   = signed_op & dividend_i[XLEN-1];
  assign dvs_neg   = signed_op & divisor_i[XLEN-1];
  assign dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag   = dvs_neg ? -divisor_i : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign ovf       = signed_op && (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (divisor_i == '1);
  assign accept    = (state == IDLE) && start_i && !annul_i;

  // One restoring step; the partial remainder never exceeds the divisor, so XLEN bits hold it.
  assign shifted   = {rem_q, quo_q[XLEN-1]};
  assign trial     = shifted - {1'b0, dvsr_q};
  assign quo_step  = {quo_q[XLEN-2:0], ~trial[XLEN]};
  assign rem_step  = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_fix   = neg_quo_q ? -quo_step : quo_step;
  assign rem_fix   = neg_rem_q ? -rem_step : rem_step;
  assign final_res = is_rem_q ? rem_fix : quo_fix;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (div_zero || ovf) ? DONE : BUSY;
      BUSY: if (cnt == LAST) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
    end else if (accept) begin
      is_rem_q  <= op_i[1];
      neg_quo_q <= dvd_neg ^ dvs_neg;
      neg_rem_q <= dvd_neg;
      if (div_zero) begin
        result_o <= op_i[1] ? dividend_i : '1;
      end else if (ovf) begin
        result_o <= op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end else begin
        cnt    <= '0;
        rem_q  <= '0;
        quo_q  <= dvd_mag;
        dvsr_q <= dvs_mag;
      end
    end else if (state == BUSY && !annul_i) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt   <= cnt + 1'b1;
      if (cnt == LAST) result_o <= final_res;
    end
  end

  assign ready_o    = rst && !annul_i && (state == DONE);
  assign stallreq_o = rst && !annul_i && (((state == IDLE) && start_i) || (state == BUSY));
  assign state_o    = state;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: driver issues divisions and checks timing, a monitor
// pops expected results from a queue whenever ready_o is seen.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         annul;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         ready, stallreq;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  div_unit #(.XLEN(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (a),
    .divisor_i  (b),
    .annul_i    (annul),
    .result_o   (result),
    .ready_o    (ready),
    .stallreq_o (stallreq),
    .state_o    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ready_o strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_ready: got ready=1 result=%h expected no pending result", result);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e);
      end
    end
  end

  // Called at #1 after a posedge (cycle T); returns at #1 after the posedge of T+lat+1.
  task automatic run_div(input string name, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] e, input int lat,
                         input bit scramble);
    int cycles;
    int stalls;
    bit got;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(e);
    cycles = 0;
    stalls = 0;
    got = 1'b0;
    while (!got && cycles <= 100) begin
      @(negedge clk);
      if (cycles == 0) check({name, "_idle_at_start"}, 32'(state), 32'd0);
      if (stallreq) stalls++;
      if (ready) got = 1'b1;
      else cycles++;
      if (scramble && cycles == 5) begin
        a = $urandom;
        b = $urandom;
        op = 2'($urandom_range(0, 3));
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no ready after %0d cycles expected ready at %0d", name, cycles, lat);
    end else begin
      check({name, "_latency"}, 32'(cycles), 32'(lat));
      check({name, "_stall_cycles"}, 32'(stalls), 32'(lat));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int rdy;
    rst = 1'b0;
    start = 1'b1;
    annul = 1'b0;
    op = 2'd1;
    a = 32'd123;
    b = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_result", result, 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_stallreq", 32'(stallreq), 32'd0);
    check("reset_state", 32'(state), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    run_div("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         33, 1'b0);
    run_div("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          33, 1'b0);
    run_div("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33, 1'b0);
    run_div("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33, 1'b0);
    run_div("divu_5_0",     2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1,  1'b0);
    run_div("rem_m5_0",     2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1,  1'b0);
    run_div("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1,  1'b0);
    run_div("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1,  1'b0);
    run_div("divu_big",     2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33, 1'b0);
    run_div("remu_big",     2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  33, 1'b0);
    run_div("div_100_m7",   2'b00, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  33, 1'b0);
    run_div("rem_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9,  32'd2,          33, 1'b0);
    run_div("div_m100_m7",  2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         33, 1'b0);
    run_div("rem_m100_m7",  2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  33, 1'b0);
    run_div("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33, 1'b0);
    run_div("divu_scramble", 2'b01, 32'd1000,      32'd3,          32'd333,        33, 1'b1);

    // Annul at T+10 of a DIVU, then a fresh start at T+12.
    op = 2'b01;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    check("annul_stall_at_t", 32'(stallreq), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("annul_busy_state", 32'(state), 32'd1);
    check("annul_stall_low", 32'(stallreq), 32'd0);
    check("annul_ready_low", 32'(ready), 32'd0);
    @(posedge clk);
    #1;
    annul = 1'b0;
    @(negedge clk);
    check("annul_idle_state", 32'(state), 32'd0);
    check("annul_idle_stall", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1;
    run_div("annul_restart", 2'b01, 32'd1000, 32'd10, 32'd100, 33, 1'b0);

    // Annul together with start in IDLE: stays IDLE.
    op = 2'b01;
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_start_stall", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    check("annul_start_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;

    // Reset pulsed at T+20 of a busy op.
    op = 2'b01;
    a = 32'hFFFF_FFFF;
    b = 32'd3;
    start = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_result", result, 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_stallreq", 32'(stallreq), 32'd0);
    check("midrst_state", 32'(state), 32'd0);
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) rdy++;
    end
    check("midrst_no_ready", 32'(rdy), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
